// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one load/store at a time over req/ack,
// stalls upstream while outstanding, aborts on timeout, registers write-back.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_readmem,
    input  logic        ex_mem_writemem,
    input  logic [31:0] ex_mem_regb,
    input  logic        ex_mem_selwsource,
    input  logic [4:0]  ex_mem_regdest,
    input  logic        ex_mem_writereg,
    input  logic [31:0] ex_mem_wbvalue,
    output logic        mem_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  mem_wb_regdest,
    output logic        mem_wb_writereg,
    output logic [31:0] mem_wb_wbvalue,
    output logic        mem_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_acc;
    logic          w_issue;
    logic          w_done;
    logic          w_abort;
    logic          w_count;
    logic          w_pass;

    assign w_acc = ex_mem_readmem | ex_mem_writemem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and step decode; ack wins over the timeout abort.
    always_comb begin
        w_state_nxt = r_state;
        mem_stall   = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_count     = 1'b0;
        w_pass      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    mem_stall   = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_pass = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    w_count   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt           <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wb_regdest  <= '0;
            mem_wb_writereg <= 1'b0;
            mem_wb_wbvalue  <= '0;
            mem_err         <= 1'b0;
        end else begin
            if (w_pass) begin
                mem_wb_regdest  <= ex_mem_regdest;
                mem_wb_writereg <= ex_mem_writereg;
                mem_wb_wbvalue  <= ex_mem_wbvalue;
            end
            if (w_issue) begin
                mem_req         <= 1'b1;
                mem_we          <= ex_mem_writemem;
                mem_addr        <= {ex_mem_wbvalue[31:2], 2'b00};
                mem_wdata       <= ex_mem_regb;
                r_cnt           <= '0;
                mem_wb_writereg <= 1'b0;
            end
            if (w_done) begin
                mem_req         <= 1'b0;
                mem_wb_regdest  <= ex_mem_regdest;
                mem_wb_writereg <= ex_mem_writereg;
                mem_wb_wbvalue  <= ex_mem_selwsource ? mem_rdata : ex_mem_wbvalue;
            end
            if (w_count) begin
                r_cnt           <= r_cnt + CW'(1);
                mem_wb_writereg <= 1'b0;
            end
            // Timed-out access is dropped and flagged until reset.
            if (w_abort) begin
                mem_req         <= 1'b0;
                mem_err         <= 1'b1;
                mem_wb_writereg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT=4).
module tb_mem_access_stage;

    logic        clock;
    logic        reset;
    logic        ex_mem_readmem;
    logic        ex_mem_writemem;
    logic [31:0] ex_mem_regb;
    logic        ex_mem_selwsource;
    logic [4:0]  ex_mem_regdest;
    logic        ex_mem_writereg;
    logic [31:0] ex_mem_wbvalue;
    logic        mem_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  mem_wb_regdest;
    logic        mem_wb_writereg;
    logic [31:0] mem_wb_wbvalue;
    logic        mem_err;

    int n_vec;
    int n_bad;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .ex_mem_readmem    (ex_mem_readmem),
        .ex_mem_writemem   (ex_mem_writemem),
        .ex_mem_regb       (ex_mem_regb),
        .ex_mem_selwsource (ex_mem_selwsource),
        .ex_mem_regdest    (ex_mem_regdest),
        .ex_mem_writereg   (ex_mem_writereg),
        .ex_mem_wbvalue    (ex_mem_wbvalue),
        .mem_stall         (mem_stall),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .mem_wb_regdest    (mem_wb_regdest),
        .mem_wb_writereg   (mem_wb_writereg),
        .mem_wb_wbvalue    (mem_wb_wbvalue),
        .mem_err           (mem_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic rd, input logic wr, input logic [31:0] regb,
                       input logic sel, input logic [4:0] rdest, input logic wreg,
                       input logic [31:0] wbv);
        ex_mem_readmem    = rd;
        ex_mem_writemem   = wr;
        ex_mem_regb       = regb;
        ex_mem_selwsource = sel;
        ex_mem_regdest    = rdest;
        ex_mem_writereg   = wreg;
        ex_mem_wbvalue    = wbv;
    endtask

    task automatic nop();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        nop();
        #12;
        chk("rst_req",     32'(mem_req), 32'h0);
        chk("rst_we",      32'(mem_we), 32'h0);
        chk("rst_addr",    mem_addr, 32'h0);
        chk("rst_wdata",   mem_wdata, 32'h0);
        chk("rst_wb_rd",   32'(mem_wb_regdest), 32'h0);
        chk("rst_wb_wr",   32'(mem_wb_writereg), 32'h0);
        chk("rst_wb_val",  mem_wb_wbvalue, 32'h0);
        chk("rst_err",     32'(mem_err), 32'h0);
        chk("rst_stall0",  32'(mem_stall), 32'h0);
        ex_mem_readmem = 1'b1;
        #1;
        chk("rst_stall1",  32'(mem_stall), 32'h1);
        nop();
        #1;
        reset = 1'b1;

        // Pass-through ALU op
        tick();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 5'd5, 1'b1, 32'h0000_1234);
        #1;
        chk("alu_stall",   32'(mem_stall), 32'h0);
        tick();
        chk("alu_wb_val",  mem_wb_wbvalue, 32'h0000_1234);
        chk("alu_wb_rd",   32'(mem_wb_regdest), 32'd5);
        chk("alu_wb_wr",   32'(mem_wb_writereg), 32'h1);

        // Load, ack in cycle 3
        drv(1'b1, 1'b0, 32'h0, 1'b1, 5'd8, 1'b1, 32'h0000_0106);
        #1;
        chk("ld_stall_c0", 32'(mem_stall), 32'h1);
        tick();
        chk("ld_req_c1",   32'(mem_req), 32'h1);
        chk("ld_addr",     mem_addr, 32'h0000_0104);
        chk("ld_we",       32'(mem_we), 32'h0);
        chk("ld_bubble",   32'(mem_wb_writereg), 32'h0);
        chk("ld_stall_c1", 32'(mem_stall), 32'h1);
        tick();
        chk("ld_stall_c2", 32'(mem_stall), 32'h1);
        chk("ld_addr_c2",  mem_addr, 32'h0000_0104);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_stall_c3", 32'(mem_stall), 32'h0);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        nop();
        chk("ld_req_done", 32'(mem_req), 32'h0);
        chk("ld_wb_val",   mem_wb_wbvalue, 32'hDEAD_BEEF);
        chk("ld_wb_rd",    32'(mem_wb_regdest), 32'd8);
        chk("ld_wb_wr",    32'(mem_wb_writereg), 32'h1);

        // Store, ack in cycle 1
        drv(1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 5'd2, 1'b0, 32'h0000_0200);
        #1;
        chk("st_stall_c0", 32'(mem_stall), 32'h1);
        tick();
        chk("st_req",      32'(mem_req), 32'h1);
        chk("st_we",       32'(mem_we), 32'h1);
        chk("st_wdata",    mem_wdata, 32'hCAFE_0001);
        chk("st_addr",     mem_addr, 32'h0000_0200);
        mem_ack = 1'b1;
        #1;
        chk("st_stall_c1", 32'(mem_stall), 32'h0);
        tick();
        mem_ack = 1'b0;
        nop();
        chk("st_req_off",  32'(mem_req), 32'h0);
        chk("st_wb_wr",    32'(mem_wb_writereg), 32'h0);

        // Ack on the final allowed cycle (cycle 4)
        drv(1'b1, 1'b0, 32'h0, 1'b1, 5'd9, 1'b1, 32'h0000_0040);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("fin_req",   32'(mem_req), 32'h1);
            chk("fin_stall", 32'(mem_stall), 32'h1);
        end
        tick();
        chk("fin_req_c4",  32'(mem_req), 32'h1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        #1;
        chk("fin_stall_c4", 32'(mem_stall), 32'h0);
        tick();
        mem_ack = 1'b0;
        nop();
        chk("fin_wb_val",  mem_wb_wbvalue, 32'h1111_2222);
        chk("fin_wb_rd",   32'(mem_wb_regdest), 32'd9);
        chk("fin_wb_wr",   32'(mem_wb_writereg), 32'h1);
        chk("fin_err",     32'(mem_err), 32'h0);

        // Timeout: no ack, req high for cycles 1..4
        tick();
        drv(1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 1'b1, 32'h0000_0300);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("to_req",    32'(mem_req), 32'h1);
            chk("to_stall",  32'(mem_stall), 32'h1);
            chk("to_err0",   32'(mem_err), 32'h0);
        end
        tick();
        chk("to_req_c4",   32'(mem_req), 32'h1);
        chk("to_stall_c4", 32'(mem_stall), 32'h0);
        tick();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 5'd7, 1'b1, 32'h0000_0077);
        chk("to_req_c5",   32'(mem_req), 32'h0);
        chk("to_err1",     32'(mem_err), 32'h1);
        chk("to_wb_wr",    32'(mem_wb_writereg), 32'h0);
        #1;
        chk("to_nx_stall", 32'(mem_stall), 32'h0);
        tick();
        nop();
        chk("to_nx_val",   mem_wb_wbvalue, 32'h0000_0077);
        chk("to_nx_rd",    32'(mem_wb_regdest), 32'd7);
        chk("to_nx_wr",    32'(mem_wb_writereg), 32'h1);
        chk("to_err_held", 32'(mem_err), 32'h1);

        // Reset asserted mid-WAIT
        drv(1'b1, 1'b0, 32'h0, 1'b1, 5'd6, 1'b1, 32'h0000_0500);
        tick();
        chk("mr_req_pre",  32'(mem_req), 32'h1);
        #2;
        reset = 1'b0;
        nop();
        #1;
        chk("mr_req",      32'(mem_req), 32'h0);
        chk("mr_addr",     mem_addr, 32'h0);
        chk("mr_err",      32'(mem_err), 32'h0);
        chk("mr_wb_val",   mem_wb_wbvalue, 32'h0);
        chk("mr_wb_rd",    32'(mem_wb_regdest), 32'h0);
        #2;
        reset = 1'b1;

        // Stray ack in IDLE has no effect
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 1'b0;
        chk("stray_req",   32'(mem_req), 32'h0);
        chk("stray_wb_wr", 32'(mem_wb_writereg), 32'h0);
        chk("stray_wb_val", mem_wb_wbvalue, 32'h0);

        // New load after reset, ack in cycle 1
        drv(1'b1, 1'b0, 32'h0, 1'b1, 5'd4, 1'b1, 32'h0000_0013);
        tick();
        chk("pr_req",      32'(mem_req), 32'h1);
        chk("pr_addr",     mem_addr, 32'h0000_0010);
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5_5A5A;
        tick();
        mem_ack = 1'b0;
        nop();
        chk("pr_req_off",  32'(mem_req), 32'h0);
        chk("pr_wb_val",   mem_wb_wbvalue, 32'hA5A5_5A5A);
        chk("pr_wb_rd",    32'(mem_wb_regdest), 32'd4);
        chk("pr_wb_wr",    32'(mem_wb_writereg), 32'h1);
        chk("pr_err",      32'(mem_err), 32'h0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
